mini16_s2m_arbiter: RTL
=======================

# mini16_s2m_arbiter

Round-robin arbiter sharing the single write port of the shared slave-to-master (s2m) memory between the CORES processing elements of mini16_soc. Each PE raises a write request with address and data; the arbiter grants at most one PE per cycle and drives the registered memory write port. It acknowledges the winner and rotates priority so no PE starves. The master CPU can freeze all grants with a lock input while it accesses the s2m memory.

## Interface
- CORES, 4, number of requesting PEs (≥2, need not be a power of two)
- WIDTH_D, 32, s2m data width
- DEPTH_S2M, 8, s2m address width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  CORES  per-PE write request; bit i belongs to PE i
- req_addr  in  CORES*DEPTH_S2M  packed addresses; PE i at [i*DEPTH_S2M +: DEPTH_S2M]
- req_data  in  CORES*WIDTH_D  packed data; PE i at [i*WIDTH_D +: WIDTH_D]
- lock  in  1  master lock; while high, no new grant
- ack  out  CORES  one-cycle pulse, bit i = PE i's write issued this cycle
- s2m_we  out  1  write enable to s2m memory
- s2m_addr  out  DEPTH_S2M  write address
- s2m_data  out  WIDTH_D  write data
- pending  out  1  registered: some eligible request was not granted last cycle

## Operation
- State: round-robin pointer ptr (clog2(CORES) bits, 0..CORES-1), last-grant mask last (CORES bits), registered outputs.
- Eligible set each cycle: req & ~last. A PE acked in the previous cycle is not eligible this cycle (its req/data are stale until it observes ack).
- If lock = 0 and eligible set non-empty: winner g = first eligible index scanning ptr, ptr+1, …, CORES-1, 0, …, ptr-1.
- On grant: s2m_we <= 1, s2m_addr <= req_addr[g], s2m_data <= req_data[g], ack <= one-hot(g), last <= one-hot(g), ptr <= (g == CORES-1) ? 0 : g+1.
- No grant (lock = 1 or eligible empty): s2m_we <= 0, ack <= 0, last <= 0; ptr unchanged; s2m_addr/s2m_data hold previous values.
- pending <= 1 when eligible set non-empty and (lock = 1 or more than one eligible bit); else 0.
- Requester rule: hold req, addr, data stable until ack seen high; in the ack cycle either drop req or present the next write (it is eligible again one cycle later).
- Requests are never dropped or reordered per PE; a withdrawn req (deasserted before ack) is simply not granted.
- lock has priority over all requests; releasing lock resumes arbitration from the unchanged ptr.

## Timing
- Reset (synchronous, dominant over all inputs): ptr = 0, last = 0, ack = 0, s2m_we = 0, s2m_addr = 0, s2m_data = 0, pending = 0.
- Latency: req sampled at edge k → s2m_we/ack/addr/data valid after edge k (one cycle); memory writes at edge k+1.
- ack and s2m_we are always coincident; popcount(ack) ≤ 1.
- Throughput: one write per cycle aggregate when ≥2 PEs request; one write per 2 cycles for a single PE.
- lock sampled at edge k blocks grant from edge k; a grant registered at the same edge lock first rises is not possible (lock is evaluated before grant).
- Reset mid-operation: an in-flight ack/we is cleared at the reset edge; requesters re-present and are rearbitrated from PE 0.
- Wrap-around: grant to PE CORES-1 sets ptr = 0.

## Test plan
- Single request: reset, then req = 0b0100, addr2 = 0x12, data2 = 0xDEADBEEF -> next cycle s2m_we = 1, ack = 0b0100, addr 0x12, data 0xDEADBEEF; ptr = 3.
- All request (CORES = 4) continuously from ptr = 0, each PE dropping req on ack -> acks 0b0001, 0b0010, 0b0100, 0b1000 on 4 consecutive cycles, s2m_we high all 4 cycles.
- Single PE 1 holding req high with new data each ack -> ack on alternate cycles only (1,0,1,0), s2m_we pattern identical.
- lock = 1 for 5 cycles with req = 0b1111 -> no ack, s2m_we = 0, pending = 1; lock drop -> grant resumes at current ptr.
- ptr = 3, req = 0b1001 -> PE 3 granted first, then PE 0 (wrap), ptr ends at 1.
- reset asserted in the cycle ack = 0b0010 is due -> ack = 0, s2m_we = 0, ptr = 0 after that edge; with req = 0b0110 held, next grant goes to PE 1.

Source files
------------

// File: rtl/mini16_s2m_arbiter.sv
// Round-robin arbiter for the single write port of the shared s2m memory.
// At most one PE wins per cycle. The memory write port and the ack pulse are both registered.
module mini16_s2m_arbiter #(
    parameter int CORES     = 4,
    parameter int WIDTH_D   = 32,
    parameter int DEPTH_S2M = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CORES-1:0]             req,
    input  logic [CORES*DEPTH_S2M-1:0]   req_addr,
    input  logic [CORES*WIDTH_D-1:0]     req_data,
    input  logic                         lock,
    output logic [CORES-1:0]             ack,
    output logic                         s2m_we,
    output logic [DEPTH_S2M-1:0]         s2m_addr,
    output logic [WIDTH_D-1:0]           s2m_data,
    output logic                         pending
);

    localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;

    // Handshake: a PE holds req/addr/data stable until it sees its ack bit high.
    // In the ack cycle it either drops req or presents its next write.
    // The PE granted last cycle is masked for one cycle, because its inputs are still stale.

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic [CORES-1:0] last;
    logic [CORES-1:0] elig;
    logic [CORES-1:0] win_oh;
    logic             found;
    logic             multi;
    logic             grant;
    int               idx;

    assign elig   = req & ~last;
    assign multi  = |(elig & (elig - CORES'(1)));
    assign grant  = found & ~lock;
    assign win_oh = CORES'(1) << win;

    // Scan from ptr and wrap around to ptr-1. The first eligible PE wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < CORES; off++) begin
            idx = int'(ptr) + off;
            if (idx >= CORES) idx = idx - CORES;
            if (!found && elig[idx]) begin
                win   = PTR_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            last     <= '0;
            ack      <= '0;
            s2m_we   <= 1'b0;
            s2m_addr <= '0;
            s2m_data <= '0;
            pending  <= 1'b0;
        end else begin
            pending <= (|elig) && (lock || multi);
            if (grant) begin
                s2m_we   <= 1'b1;
                s2m_addr <= req_addr[int'(win)*DEPTH_S2M +: DEPTH_S2M];
                s2m_data <= req_data[int'(win)*WIDTH_D +: WIDTH_D];
                ack      <= win_oh;
                last     <= win_oh;
                ptr      <= (win == PTR_W'(CORES-1)) ? '0 : win + PTR_W'(1);
            end else begin
                s2m_we <= 1'b0;
                ack    <= '0;
                last   <= '0;
            end
        end
    end

endmodule
